// File: rtl/square_wave_analyzer.sv
// Square-wave decoder. Watches a signed sample stream and recovers the period,
// duty cycle and volume of each completed wave cycle, one measurement per
// rising edge once locked.
module square_wave_analyzer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty_cycle,
  output logic [WIDTH-1:0] volume,
  output logic             meas_valid,
  output logic             stable,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_SYNC,
    S_HIGH,
    S_LOW
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] duty_acc, duty_acc_n;
  logic [WIDTH-1:0] vol_lat, vol_lat_n;
  logic [WIDTH-1:0] period_n, duty_cycle_n, volume_n;
  logic             meas_valid_n, stable_n, overflow_n;
  // Level starts as HIGH so a HIGH run already in progress at reset is not
  // mistaken for a rising edge; an actual LOW must be seen first.
  logic             lvl_high, lvl_high_n;
  logic             have_prev, have_prev_n;

  logic is_hi, is_lo, rise, fall, cnt_max;

  assign is_hi   = ~sample[WIDTH-1] && (sample != '0);
  assign is_lo   = sample[WIDTH-1];
  assign rise    = is_hi && !lvl_high;
  assign fall    = is_lo && lvl_high;
  assign cnt_max = (cnt == '1);

  // Next-state, counter and measurement logic for one valid sample.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    duty_acc_n   = duty_acc;
    vol_lat_n    = vol_lat;
    lvl_high_n   = lvl_high;
    have_prev_n  = have_prev;
    period_n     = period;
    duty_cycle_n = duty_cycle;
    volume_n     = volume;
    stable_n     = stable;
    meas_valid_n = 1'b0;
    overflow_n   = 1'b0;

    if (sample_valid) begin
      if (is_hi) begin
        lvl_high_n = 1'b1;
      end else if (is_lo) begin
        lvl_high_n = 1'b0;
      end

      unique case (state)
        S_SYNC: begin
          if (rise) begin
            cnt_n     = WIDTH'(1);
            vol_lat_n = sample;
            state_n   = S_HIGH;
          end
        end

        S_HIGH: begin
          // Every valid sample in the HIGH phase needs an increment.
          if (cnt_max) begin
            overflow_n  = 1'b1;
            stable_n    = 1'b0;
            have_prev_n = 1'b0;
            cnt_n       = '0;
            state_n     = S_SYNC;
          end else if (fall) begin
            duty_acc_n = cnt;
            cnt_n      = cnt + WIDTH'(1);
            state_n    = S_LOW;
          end else begin
            cnt_n = cnt + WIDTH'(1);
            if (is_hi) begin
              vol_lat_n = sample;
            end
          end
        end

        S_LOW: begin
          // A rising edge wins over saturation: cnt is reported as-is.
          if (rise) begin
            period_n     = cnt;
            duty_cycle_n = duty_acc;
            volume_n     = vol_lat;
            meas_valid_n = 1'b1;
            stable_n     = have_prev && (cnt == period) &&
                           (duty_acc == duty_cycle) && (vol_lat == volume);
            have_prev_n  = 1'b1;
            cnt_n        = WIDTH'(1);
            vol_lat_n    = sample;
            state_n      = S_HIGH;
          end else if (cnt_max) begin
            overflow_n  = 1'b1;
            stable_n    = 1'b0;
            have_prev_n = 1'b0;
            cnt_n       = '0;
            state_n     = S_SYNC;
          end else begin
            cnt_n = cnt + WIDTH'(1);
          end
        end

        default: state_n = S_SYNC;
      endcase
    end
  end

  // State, counters and registered outputs; reset discards any partial cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_SYNC;
      cnt        <= '0;
      duty_acc   <= '0;
      vol_lat    <= '0;
      lvl_high   <= 1'b1;
      have_prev  <= 1'b0;
      period     <= '0;
      duty_cycle <= '0;
      volume     <= '0;
      meas_valid <= 1'b0;
      stable     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      duty_acc   <= duty_acc_n;
      vol_lat    <= vol_lat_n;
      lvl_high   <= lvl_high_n;
      have_prev  <= have_prev_n;
      period     <= period_n;
      duty_cycle <= duty_cycle_n;
      volume     <= volume_n;
      meas_valid <= meas_valid_n;
      stable     <= stable_n;
      overflow   <= overflow_n;
    end
  end

endmodule

// File: tb/tb_square_wave_analyzer.sv
// Bench for square_wave_analyzer: timestamp-based reference model checked every
// cycle, plus literal expectations on directed scenarios and a random phase.
module tb_square_wave_analyzer;

  localparam int    W    = 16;
  localparam longint MAXC = 65535;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sample = '0;
  logic         sample_valid = 1'b0;
  logic [W-1:0] period, duty_cycle, volume;
  logic         meas_valid, stable, overflow;

  square_wave_analyzer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .period       (period),
    .duty_cycle   (duty_cycle),
    .volume       (volume),
    .meas_valid   (meas_valid),
    .stable       (stable),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: positions of valid samples, measured as indices.
  longint       m_idx = 0, m_trise = 0, m_tfall = -1;
  bit           m_lvl = 1'b1, m_locked = 1'b0, m_have = 1'b0;
  logic [W-1:0] m_vol = '0;
  logic [W-1:0] e_period = '0, e_duty = '0, e_vol = '0;
  bit           e_mv = 1'b0, e_ov = 1'b0, e_st = 1'b0;
  bit           model_live = 1'b0;

  task automatic model_step(input logic [W-1:0] s);
    bit hi, lo, rise, fall;
    longint c;
    logic [W-1:0] p, d;
    hi   = (s[W-1] == 1'b0) && (s != '0);
    lo   = s[W-1];
    rise = hi && !m_lvl;
    fall = lo && m_lvl;
    if (m_locked) begin
      c = m_idx - m_trise;
      if (rise) begin
        p = W'(c);
        d = W'(m_tfall - m_trise);
        e_st = m_have && (p == e_period) && (d == e_duty) && (m_vol == e_vol);
        e_period = p;
        e_duty   = d;
        e_vol    = m_vol;
        e_mv     = 1'b1;
        m_have   = 1'b1;
        m_trise  = m_idx;
        m_tfall  = -1;
        m_vol    = s;
      end else if (c >= MAXC) begin
        e_ov     = 1'b1;
        e_st     = 1'b0;
        m_locked = 1'b0;
        m_have   = 1'b0;
      end else begin
        if (fall) m_tfall = m_idx;
        if (hi) m_vol = s;
      end
    end else if (rise) begin
      m_locked = 1'b1;
      m_trise  = m_idx;
      m_tfall  = -1;
      m_vol    = s;
    end
    if (hi) m_lvl = 1'b1;
    else if (lo) m_lvl = 1'b0;
    m_idx++;
  endtask

  always @(posedge clk) begin
    e_mv = 1'b0;
    e_ov = 1'b0;
    if (rst) begin
      model_live = 1'b1;
      m_lvl = 1'b1; m_locked = 1'b0; m_have = 1'b0; m_vol = '0; m_tfall = -1;
      e_period = '0; e_duty = '0; e_vol = '0; e_st = 1'b0;
    end else if (sample_valid) begin
      model_step(sample);
    end
  end

  typedef struct {
    longint       cyc;
    logic [W-1:0] p, d, v;
    logic         st;
  } meas_t;
  meas_t  log_q[$];
  int     ov_count = 0;
  longint cyc = 0;

  always @(negedge clk) begin
    if (model_live) begin
      cyc++;
      check("meas_valid", 64'(meas_valid), 64'(e_mv));
      check("overflow",   64'(overflow),   64'(e_ov));
      check("stable",     64'(stable),     64'(e_st));
      check("period",     64'(period),     64'(e_period));
      check("duty_cycle", 64'(duty_cycle), 64'(e_duty));
      check("volume",     64'(volume),     64'(e_vol));
      if (meas_valid === 1'b1) log_q.push_back('{cyc, period, duty_cycle, volume, stable});
      if (overflow === 1'b1) ov_count++;
    end
  end

  task automatic drive(input logic [W-1:0] s, input bit v);
    @(negedge clk);
    rst = 1'b0;
    sample = s;
    sample_valid = v;
  endtask

  task automatic flush();
    repeat (2) drive('0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample = W'($urandom);
    sample_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b0;
    check("reset_period", 64'(period), 64'd0);
    check("reset_duty",   64'(duty_cycle), 64'd0);
    check("reset_volume", 64'(volume), 64'd0);
    check("reset_flags",  64'({meas_valid, stable, overflow}), 64'd0);
  endtask

  task automatic wave(input int p, input int d, input logic [W-1:0] hi,
                      input logic [W-1:0] lo, input int reps, input bit sparse);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < p; i++) begin
        drive((i < d) ? hi : lo, 1'b1);
        if (sparse) drive(W'($urandom), 1'b0);
      end
  endtask

  task automatic expect_meas(input string tag, input int idx, input logic [W-1:0] p,
                             input logic [W-1:0] d, input logic [W-1:0] v, input bit st);
    if (idx >= log_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: measurement %0d missing, got %0d measurements", tag, idx, log_q.size());
    end else begin
      check({tag, "_period"}, 64'(log_q[idx].p), 64'(p));
      check({tag, "_duty"},   64'(log_q[idx].d), 64'(d));
      check({tag, "_volume"}, 64'(log_q[idx].v), 64'(v));
      check({tag, "_stable"}, 64'(log_q[idx].st), 64'(st));
    end
  endtask

  initial begin
    int unsigned p, d, reps;
    logic [W-1:0] hi, lo, s;

    do_reset();

    // Basic 8/3 stream.
    log_q.delete();
    wave(8, 3, 16'h1000, 16'hF000, 4, 1'b0);
    drive(16'h1000, 1'b1);
    flush();
    check("t1_count", 64'(log_q.size()), 64'd3);
    expect_meas("t1_first", 0, 16'd8, 16'd3, 16'h1000, 1'b0);
    expect_meas("t1_second", 1, 16'd8, 16'd3, 16'h1000, 1'b1);
    if (log_q.size() >= 2) check("t1_spacing", 64'(log_q[1].cyc - log_q[0].cyc), 64'd8);

    // Same stream with invalid cycles interleaved.
    do_reset();
    log_q.delete();
    wave(8, 3, 16'h1000, 16'hF000, 4, 1'b1);
    drive(16'h1000, 1'b1);
    flush();
    check("t2_count", 64'(log_q.size()), 64'd3);
    expect_meas("t2_first", 0, 16'd8, 16'd3, 16'h1000, 1'b0);
    expect_meas("t2_second", 1, 16'd8, 16'd3, 16'h1000, 1'b1);
    if (log_q.size() >= 2) check("t2_spacing", 64'(log_q[1].cyc - log_q[0].cyc), 64'd16);

    // Switch to 5/1/0x0800 at a rising edge.
    log_q.delete();
    repeat (2) drive(16'h1000, 1'b1);
    repeat (5) drive(16'hF000, 1'b1);
    wave(5, 1, 16'h0800, 16'hF800, 3, 1'b0);
    drive(16'h0800, 1'b1);
    flush();
    check("t3_count", 64'(log_q.size()), 64'd4);
    expect_meas("t3_old", 0, 16'd8, 16'd3, 16'h1000, 1'b1);
    expect_meas("t3_new", 1, 16'd5, 16'd1, 16'h0800, 1'b0);
    expect_meas("t3_lock", 2, 16'd5, 16'd1, 16'h0800, 1'b1);

    // Constant HIGH saturates the counter.
    log_q.delete();
    ov_count = 0;
    repeat (65536) drive(16'h1000, 1'b1);
    flush();
    check("t4_ov_count", 64'(ov_count), 64'd1);
    check("t4_no_meas", 64'(log_q.size()), 64'd0);
    check("t4_hold_period", 64'(period), 64'd5);
    check("t4_hold_duty", 64'(duty_cycle), 64'd1);
    check("t4_hold_volume", 64'(volume), 64'h0800);
    check("t4_stable", 64'(stable), 64'd0);
    wave(8, 3, 16'h1000, 16'hF000, 3, 1'b0);
    drive(16'h1000, 1'b1);
    flush();
    check("t4_restore_count", 64'(log_q.size()), 64'd2);
    expect_meas("t4_restore", 0, 16'd8, 16'd3, 16'h1000, 1'b0);

    // All zeros never count; zeros inside a HIGH run extend it.
    do_reset();
    log_q.delete();
    ov_count = 0;
    repeat (40) drive('0, 1'b1);
    flush();
    check("t5_zero_meas", 64'(log_q.size()), 64'd0);
    check("t5_zero_ov", 64'(ov_count), 64'd0);
    repeat (3) drive(16'hF000, 1'b1);
    repeat (2) begin
      drive(16'h1000, 1'b1);
      drive(16'h0000, 1'b1);
      drive(16'h1000, 1'b1);
      repeat (5) drive(16'hF000, 1'b1);
    end
    drive(16'h1000, 1'b1);
    flush();
    expect_meas("t5_zero_in_high", 0, 16'd8, 16'd3, 16'h1000, 1'b0);

    // Reset in the middle of a LOW phase.
    do_reset();
    wave(8, 3, 16'h1000, 16'hF000, 3, 1'b0);
    repeat (3) drive(16'h1000, 1'b1);
    repeat (2) drive(16'hF000, 1'b1);
    do_reset();
    log_q.delete();
    repeat (3) drive(16'hF000, 1'b1);
    wave(8, 3, 16'h1000, 16'hF000, 2, 1'b0);
    drive(16'h1000, 1'b1);
    flush();
    check("t6_count", 64'(log_q.size()), 64'd2);
    expect_meas("t6_after_reset", 0, 16'd8, 16'd3, 16'h1000, 1'b0);

    // Random waves with zeros, invalid cycles and occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      p    = $urandom_range(2, 24);
      d    = $urandom_range(1, p - 1);
      reps = $urandom_range(1, 6);
      hi   = W'($urandom_range(1, 16'h7FFF));
      lo   = W'(16'h8000 | $urandom_range(0, 16'h7FFF));
      for (int r = 0; r < int'(reps); r++)
        for (int i = 0; i < int'(p); i++) begin
          s = (i < int'(d)) ? hi : lo;
          if ($urandom_range(0, 7) == 0) s = '0;
          while ($urandom_range(0, 7) == 0) drive(W'($urandom), 1'b0);
          drive(s, 1'b1);
        end
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
